// File: rtl/vg75_ctrl.sv
// vg75_ctrl: CPU-side register block of a VG75-style CRT controller (commands, parameters, status, IRQ).
// Define VG75_CTRL_DMA_EN to enable the byte-wide DMA base-address write port.
module vg75_ctrl (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        we,
   input  logic        rd,
   input  logic        a0,
   input  logic [7:0]  din,
   output logic [7:0]  dout,
   input  logic        frame_tick,
   input  logic        base_we,
   input  logic [7:0]  base_din,
   output logic        irq,
   output logic        video_en,
   output logic [6:0]  cursor_x,
   output logic [5:0]  cursor_y,
   output logic [2:0]  sym_height,
   output logic [1:0]  sym_gap,
   output logic [6:0]  chars_per_row,
   output logic [5:0]  rows_per_frame,
   output logic [15:0] base_address,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RST_P1 = 3'd1,
      S_RST_P2 = 3'd2,
      S_RST_P3 = 3'd3,
      S_RST_P4 = 3'd4,
      S_CUR_P1 = 3'd5,
      S_CUR_P2 = 3'd6
   } state_t;

   state_t     state, next_state;
   logic       ie, ir, ic;
   logic [6:0] sh_p1;
   logic [5:0] sh_p2;
   logic [2:0] sh_height;
   logic [1:0] sh_gap;

   // Bus strobes are single-cycle and qualified by cs; a cycle carrying both we and rd is a write only.
   logic       wr_cyc, rd_cyc, cmd_wr, par_wr, stat_rd, par_rd, di_cmd;
   logic [2:0] op;
   logic       abort, par_idle, commit_rst, commit_cur;

   assign wr_cyc  = cs & we;
   assign rd_cyc  = cs & rd & ~we;
   assign cmd_wr  = wr_cyc & a0;
   assign par_wr  = wr_cyc & ~a0;
   assign stat_rd = rd_cyc & a0;
   assign par_rd  = rd_cyc & ~a0;
   assign op      = din[7:5];
   assign di_cmd  = cmd_wr & (op == 3'b110);

   always_comb begin
      next_state = state;
      abort      = 1'b0;
      par_idle   = 1'b0;
      commit_rst = 1'b0;
      commit_cur = 1'b0;
      if (cmd_wr) begin
         abort = (state != S_IDLE);
         case (op)
            3'b000:  next_state = S_RST_P1;
            3'b100:  next_state = S_CUR_P1;
            default: next_state = S_IDLE;
         endcase
      end else if (par_wr) begin
         case (state)
            S_IDLE:   par_idle = 1'b1;
            S_RST_P1: next_state = S_RST_P2;
            S_RST_P2: next_state = S_RST_P3;
            S_RST_P3: next_state = S_RST_P4;
            S_RST_P4: begin
               next_state = S_IDLE;
               commit_rst = 1'b1;
            end
            S_CUR_P1: next_state = S_CUR_P2;
            S_CUR_P2: begin
               next_state = S_IDLE;
               commit_cur = 1'b1;
            end
            default:  next_state = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   // Shadow registers; the gap is reduced to its 2-bit result as soon as P3 arrives.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sh_p1     <= 7'd0;
         sh_p2     <= 6'd0;
         sh_height <= 3'd0;
         sh_gap    <= 2'd0;
      end else if (par_wr) begin
         case (state)
            S_RST_P1, S_CUR_P1: sh_p1 <= din[6:0];
            S_RST_P2:           sh_p2 <= din[5:0];
            S_RST_P3: begin
               sh_height <= din[6:4];
               sh_gap    <= din[1:0] - din[5:4];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         chars_per_row  <= 7'd79;
         rows_per_frame <= 6'd29;
         sym_height     <= 3'd7;
         sym_gap        <= 2'd2;
         cursor_x       <= 7'd0;
         cursor_y       <= 6'd0;
      end else begin
         if (commit_rst) begin
            chars_per_row  <= sh_p1;
            rows_per_frame <= sh_p2;
            sym_height     <= sh_height;
            sym_gap        <= sh_gap;
         end
         if (commit_cur) begin
            cursor_x <= sh_p1;
            cursor_y <= din[5:0];
         end
      end
   end

   // Priorities: DI beats a frame tick, a frame tick beats the status-read clear.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         video_en <= 1'b0;
         ie       <= 1'b0;
         ir       <= 1'b0;
         ic       <= 1'b0;
         dout     <= 8'h00;
      end else begin
         if (cmd_wr) begin
            case (op)
               3'b000: begin
                  video_en <= 1'b0;
                  ie       <= 1'b0;
               end
               3'b001:  video_en <= 1'b1;
               3'b010:  video_en <= 1'b0;
               3'b101:  ie <= 1'b1;
               3'b110:  ie <= 1'b0;
               default: ;
            endcase
         end
         if (di_cmd)                 ir <= 1'b0;
         else if (frame_tick && ie)  ir <= 1'b1;
         else if (stat_rd)           ir <= 1'b0;
         if (abort || par_idle)      ic <= 1'b1;
         else if (stat_rd)           ic <= 1'b0;
         if (stat_rd)     dout <= {1'b0, ie, ir, 1'b0, ic, video_en, 2'b00};
         else if (par_rd) dout <= 8'h00;
      end
   end

   assign irq       = ir;
   assign dbg_state = state;

`ifdef VG75_CTRL_DMA_EN
   logic       byte_hi;
   logic [7:0] base_lo;

   // Low byte is held until the high byte arrives so the address changes atomically.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         byte_hi      <= 1'b0;
         base_lo      <= 8'h00;
         base_address <= 16'hE6A0;
      end else if (base_we) begin
         if (!byte_hi) begin
            base_lo <= base_din;
            byte_hi <= 1'b1;
         end else begin
            base_address <= {base_din, base_lo};
            byte_hi      <= 1'b0;
         end
      end
   end
`else
   logic unused_dma;
   assign unused_dma   = &{1'b0, base_we, base_din};
   assign base_address = 16'hE6A0;
`endif

endmodule

// File: tb/tb_vg75_ctrl.sv
// Scoreboard bench for vg75_ctrl: a transaction-level model predicts every output each cycle.
`timescale 1ns/1ps
module tb_vg75_ctrl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        cs = 1'b0, we = 1'b0, rd = 1'b0, a0 = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        frame_tick = 1'b0, base_we = 1'b0;
   logic [7:0]  base_din = 8'h00;
   logic [7:0]  dout;
   logic        irq, video_en;
   logic [6:0]  cursor_x, chars_per_row;
   logic [5:0]  cursor_y, rows_per_frame;
   logic [2:0]  sym_height, dbg_state;
   logic [1:0]  sym_gap;
   logic [15:0] base_address;

   vg75_ctrl dut (
      .clock(clock), .reset_n(reset_n), .cs(cs), .we(we), .rd(rd), .a0(a0),
      .din(din), .dout(dout), .frame_tick(frame_tick), .base_we(base_we),
      .base_din(base_din), .irq(irq), .video_en(video_en), .cursor_x(cursor_x),
      .cursor_y(cursor_y), .sym_height(sym_height), .sym_gap(sym_gap),
      .chars_per_row(chars_per_row), .rows_per_frame(rows_per_frame),
      .base_address(base_address), .dbg_state(dbg_state)
   );

   always #20 clock = ~clock;

   typedef struct packed {
      logic [7:0]  dout;
      logic        irq;
      logic        video_en;
      logic [6:0]  cx;
      logic [5:0]  cy;
      logic [2:0]  sh;
      logic [1:0]  sg;
      logic [6:0]  cpr;
      logic [5:0]  rpf;
      logic [15:0] base;
   } snap_t;
   localparam int SNAP_W = $bits(snap_t);

   logic [SNAP_W-1:0] exp_q[$];
   int checks = 0;
   int failures = 0;

   function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model state
   logic        m_ie, m_ir, m_ic, m_ven, m_hi;
   logic [7:0]  m_dout, m_lo;
   logic [6:0]  m_cx, m_cpr;
   logic [5:0]  m_cy, m_rpf;
   logic [2:0]  m_sh;
   logic [1:0]  m_sg;
   logic [15:0] m_base;
   int          pend;
   logic [7:0]  m_par[$];

   function automatic void model_step(input bit rst_n, input bit c, input bit w, input bit r,
                                      input bit a, input logic [7:0] d, input bit ft,
                                      input bit bw, input logic [7:0] bd);
      bit wr, rdv, old_ie;
      logic [7:0] p3;
      int gap;
      if (!rst_n) begin
         m_ie = 0; m_ir = 0; m_ic = 0; m_ven = 0; m_hi = 0; m_lo = 8'h00;
         m_dout = 8'h00; m_cx = 0; m_cy = 0; m_sh = 3'd7; m_sg = 2'd2;
         m_cpr = 7'd79; m_rpf = 6'd29; m_base = 16'hE6A0; pend = 0;
         m_par.delete();
         return;
      end
      wr = c && w;
      rdv = c && r && !w;
      old_ie = m_ie;
      if (rdv) m_dout = a ? {1'b0, m_ie, m_ir, 1'b0, m_ic, m_ven, 2'b00} : 8'h00;
      if (rdv && a) begin
         m_ir = 0;
         m_ic = 0;
      end
      if (ft && old_ie) m_ir = 1;
      if (wr && a) begin
         if (pend != 0) m_ic = 1;
         pend = 0;
         m_par.delete();
         case (d[7:5])
            3'd0: begin pend = 4; m_ven = 0; m_ie = 0; end
            3'd1: m_ven = 1;
            3'd2: m_ven = 0;
            3'd4: pend = 2;
            3'd5: m_ie = 1;
            3'd6: begin m_ie = 0; m_ir = 0; end
            default: ;
         endcase
      end else if (wr) begin
         if (pend == 0) m_ic = 1;
         else begin
            m_par.push_back(d);
            if (m_par.size() == pend) begin
               if (pend == 4) begin
                  m_cpr = m_par[0][6:0];
                  m_rpf = m_par[1][5:0];
                  p3 = m_par[2];
                  m_sh = p3[6:4];
                  gap = int'(p3 & 8'h0F) - int'((p3 >> 4) & 8'h07);
                  m_sg = gap[1:0];
               end else begin
                  m_cx = m_par[0][6:0];
                  m_cy = m_par[1][5:0];
               end
               pend = 0;
               m_par.delete();
            end
         end
      end
`ifdef VG75_CTRL_DMA_EN
      if (bw) begin
         if (!m_hi) begin
            m_lo = bd;
            m_hi = 1;
         end else begin
            m_base = {bd, m_lo};
            m_hi = 0;
         end
      end
`else
      if (bw) m_lo = bd;
`endif
   endfunction

   task automatic do_cycle(input bit rst_n, input bit c, input bit w, input bit r, input bit a,
                           input logic [7:0] d, input bit ft, input bit bw, input logic [7:0] bd);
      snap_t s;
      @(negedge clock);
      reset_n = rst_n; cs = c; we = w; rd = r; a0 = a; din = d;
      frame_tick = ft; base_we = bw; base_din = bd;
      @(posedge clock);
      model_step(rst_n, c, w, r, a, d, ft, bw, bd);
      #1;
      s.dout = m_dout; s.irq = m_ir; s.video_en = m_ven; s.cx = m_cx; s.cy = m_cy;
      s.sh = m_sh; s.sg = m_sg; s.cpr = m_cpr; s.rpf = m_rpf; s.base = m_base;
      exp_q.push_back(s);
      reset_n = 1'b1; cs = 1'b0; we = 1'b0; rd = 1'b0; frame_tick = 1'b0; base_we = 1'b0;
   endtask

   task automatic idle();             do_cycle(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00); endtask
   task automatic rst_cycle();        do_cycle(0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00); endtask
   task automatic cmd(input logic [7:0] d); do_cycle(1, 1, 1, 0, 1, d, 0, 0, 8'h00); endtask
   task automatic par(input logic [7:0] d); do_cycle(1, 1, 1, 0, 0, d, 0, 0, 8'h00); endtask
   task automatic rd_stat();          do_cycle(1, 1, 0, 1, 1, 8'h00, 0, 0, 8'h00); endtask
   task automatic rd_par();           do_cycle(1, 1, 0, 1, 0, 8'h00, 0, 0, 8'h00); endtask
   task automatic tick();             do_cycle(1, 0, 0, 0, 0, 8'h00, 1, 0, 8'h00); endtask
   task automatic base_wr(input logic [7:0] b); do_cycle(1, 0, 0, 0, 0, 8'h00, 0, 1, b); endtask

   // Monitor: one expected snapshot per driven cycle, compared half a clock after the edge.
   snap_t e;
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("dout", 16'(dout), 16'(e.dout));
         check("irq", 16'(irq), 16'(e.irq));
         check("video_en", 16'(video_en), 16'(e.video_en));
         check("cursor_x", 16'(cursor_x), 16'(e.cx));
         check("cursor_y", 16'(cursor_y), 16'(e.cy));
         check("sym_height", 16'(sym_height), 16'(e.sh));
         check("sym_gap", 16'(sym_gap), 16'(e.sg));
         check("chars_per_row", 16'(chars_per_row), 16'(e.cpr));
         check("rows_per_frame", 16'(rows_per_frame), 16'(e.rpf));
         check("base_address", base_address, e.base);
      end
   end

   initial begin
      bit rr, cc, ww, rdd, aa, ft, bw;
      logic [7:0] dd;
      // Reset and status read
      rst_cycle();
      rst_cycle();
      rd_stat();
      idle();
      check("reset_status", 16'(dout), 16'h00);
      check("reset_cpr", 16'(chars_per_row), 16'd79);
      check("reset_base", base_address, 16'hE6A0);

      // RESET with non-default values, partial sequence must not leak out
      cmd(8'h00); par(8'h27); par(8'h0F);
      idle();
      check("partial_cpr", 16'(chars_per_row), 16'd79);
      par(8'h54); par(8'hFF);
      idle();
      check("rst_cpr", 16'(chars_per_row), 16'd39);
      check("rst_rpf", 16'(rows_per_frame), 16'd15);
      check("rst_height", 16'(sym_height), 16'd5);
      check("rst_gap", 16'(sym_gap), 16'd3);

      // Standard RESET values
      cmd(8'h00); par(8'h4F); par(8'h1D); par(8'h79); par(8'h00);
      idle();
      check("std_cpr", 16'(chars_per_row), 16'd79);
      check("std_rpf", 16'(rows_per_frame), 16'd29);
      check("std_height", 16'(sym_height), 16'd7);
      check("std_gap", 16'(sym_gap), 16'd2);

      // Aborted cursor load followed by START
      cmd(8'h80); par(8'h05); cmd(8'h20);
      rd_stat();
      idle();
      check("abort_status", 16'(dout), 16'h0C);
      check("abort_cursor_x", 16'(cursor_x), 16'd0);
      rd_stat();
      idle();
      check("abort_status2", 16'(dout), 16'h04);

      // EI, frame tick, status read
      cmd(8'hA0); tick();
      idle();
      check("irq_set", 16'(irq), 16'd1);
      rd_stat();
      idle();
      check("irq_status", 16'(dout), 16'h64);
      check("irq_cleared", 16'(irq), 16'd0);
      rd_par();
      idle();
      check("param_read", 16'(dout), 16'h00);

      // Full cursor load
      cmd(8'h80); par(8'h12); par(8'h0A);
      idle();
      check("cursor_x", 16'(cursor_x), 16'd18);
      check("cursor_y", 16'(cursor_y), 16'd10);

      // DMA base address
      base_wr(8'h00); base_wr(8'hC0);
      idle();
`ifdef VG75_CTRL_DMA_EN
      check("base_dma", base_address, 16'hC000);
`else
      check("base_fixed", base_address, 16'hE6A0);
`endif

      // Reset in the middle of a cursor load
      cmd(8'h80); par(8'h10); rst_cycle(); par(8'h03);
      rd_stat();
      idle();
      check("midreset_status", 16'(dout), 16'h08);
      check("midreset_cx", 16'(cursor_x), 16'd0);
      check("midreset_cy", 16'(cursor_y), 16'd0);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         rr  = ($urandom_range(0, 199) != 0);
         cc  = ($urandom_range(0, 3) != 0);
         ww  = ($urandom_range(0, 2) == 0);
         rdd = ($urandom_range(0, 2) == 0);
         aa  = ($urandom_range(0, 1) == 1);
         dd  = 8'($urandom);
         ft  = ($urandom_range(0, 5) == 0);
         bw  = ($urandom_range(0, 5) == 0);
         do_cycle(rr, cc, ww, rdd, aa, dd, ft, bw, 8'($urandom));
      end

      for (int k = 0; k < 20; k++) begin
         if (exp_q.size() == 0) break;
         @(negedge clock);
      end
      check("drain", 16'(exp_q.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vg75_ctrl.md
VG75_CTRL -- requirements
Module: vg75_ctrl

Interface
REQ-001 clock  in  1  system clock, 25 MHz; all state changes on rising edge.
REQ-002 reset_n  in  1  reset, synchronous, active-low.
REQ-003 cs  in  1  chip select from CPU address decoder.
REQ-004 we  in  1  write strobe, one clock wide, qualified by cs.
REQ-005 rd  in  1  read strobe, one clock wide, qualified by cs.
REQ-006 a0  in  1  port select: 0 = parameter register, 1 = command (write) / status (read).
REQ-007 din  in  8  CPU write data.
REQ-008 dout  out  8  CPU read data, registered.
REQ-009 frame_tick  in  1  one-clock pulse from display side at end of each frame.
REQ-010 base_we  in  1  DMA base-address byte write strobe, one clock wide.
REQ-011 base_din  in  8  DMA base-address byte.
REQ-012 irq  out  1  interrupt request, equal to status bit IR.
REQ-013 video_en  out  1  display enable toward display side.
REQ-014 cursor_x  out  7, cursor_y  out  6  cursor character position.
REQ-015 sym_height  out  3, sym_gap  out  2  glyph rows minus 1 and interline gap rows.
REQ-016 chars_per_row  out  7, rows_per_frame  out  6  row length minus 1 and row count minus 1.
REQ-017 base_address  out  16  video memory start address.

Function
REQ-018 Command write (cs&we&a0) SHALL decode din[7:5]: 000 RESET (4 params), 001 START, 010 STOP, 100 LOAD CURSOR (2 params), 101 EI, 110 DI, 011/111 accepted as no-op with 0 params.
REQ-019 FSM states SHALL be IDLE, RST_P1..RST_P4, CUR_P1, CUR_P2; RESET -> RST_P1, LOAD CURSOR -> CUR_P1; each parameter write (cs&we&~a0) advances one state; final parameter returns to IDLE.
REQ-020 RESET command SHALL also clear video_en and IE immediately on the command write.
REQ-021 Parameters SHALL be staged in shadow registers; outputs SHALL update together one clock after the final parameter write, never partially.
REQ-022 RESET mapping: P1[6:0] -> chars_per_row; P2[5:0] -> rows_per_frame; P3[6:4] -> sym_height; (P3[3:0] - P3[6:4]) low 2 bits -> sym_gap; P4 ignored.
REQ-023 LOAD CURSOR mapping: P1[6:0] -> cursor_x, P2[5:0] -> cursor_y; no range clipping.
REQ-024 START SHALL set video_en; STOP SHALL clear it; both take effect next clock; EI sets IE, DI clears IE and IR.
REQ-025 Command written while parameters pending SHALL abort the pending sequence (shadow discarded, outputs unchanged), set IC, and start the new command.
REQ-026 Parameter write in IDLE SHALL be ignored and set IC.
REQ-027 Status byte SHALL be {0, IE, IR, 0, IC, video_en, 0, 0}; cs&rd&a0 loads it into dout next clock and clears IR and IC at the same edge.
REQ-028 cs&rd&~a0 SHALL load dout with 8'h00, no side effects.
REQ-029 frame_tick with IE=1 SHALL set IR next clock; frame_tick coinciding with status read SHALL leave IR=1 (set wins).
REQ-030 base_we SHALL write base_din to base_address low byte, then high byte, alternating via byte flip-flop; high-byte write updates the register that same edge.
REQ-031 we and rd asserted together SHALL be treated as write only.

Reset
REQ-032 While reset_n=0 at a clock edge: FSM IDLE, dout=0, irq=0, IE=IR=IC=0, video_en=0, cursor_x=0, cursor_y=0, sym_height=7, sym_gap=2, chars_per_row=79, rows_per_frame=29, base_address=16'hE6A0, byte flip-flop = low.
REQ-033 Reset mid-sequence SHALL discard staged parameters; no output change other than reset values.

Configuration
REQ-034 Macro VG75_CTRL_DMA_EN defined: base_we/base_din active per REQ-030.
REQ-035 VG75_CTRL_DMA_EN undefined: base_we/base_din ignored, base_address constant 16'hE6A0, byte flip-flop absent.

Verification
REQ-036 Reset, then read status -> dout=8'h00, all outputs at REQ-032 values.
REQ-037 Cmd 8'h00, params 8'h4F,8'h1D,8'h79,8'h00 -> chars_per_row=79, rows_per_frame=29, sym_height=7, sym_gap=2, all one clock after 4th param.
REQ-038 Cmd 8'h80, param 8'h05, then cmd 8'h20 -> cursor unchanged, video_en=1, status 8'h0C then 8'h04 on second read.
REQ-039 Cmd 8'hA0, frame_tick pulse -> irq=1; status read -> dout=8'h64, irq=0 next clock.
REQ-040 base_we bytes 8'h00, 8'hC0 -> base_address=16'hC000 (DMA_EN); without macro stays 16'hE6A0.
REQ-041 Cmd 8'h80, param 8'h10, reset_n=0 one clock, param 8'h03 -> IC=1, cursor (0,0).
